tag_mem_array: RTL and testbench

Synchronous memory-array responder sitting on the far side of the tag memory interface: it receives the `mem_sel`/`PC_B`/`WE`/`SE`/`mem_address`/data strobes issued by the tag's memory controller and services them against three banks: EPC, sensor-1 and sensor-2. Each bank holds `DEPTH` words of 16 bits. Read data is returned on the bus the controller samples as `mem_read_in`. The block also flags protocol violations. It is the synthesizable stand-in for the memory macro in simulation and FPGA builds.

---
 rtl/tag_mem_array_if.sv | 24 ++
 rtl/tag_mem_array.sv | 174 +++++++++++++++++
 tb/tb_tag_mem_array.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tag_mem_array_if.sv
// Tag memory bus between the controller (master) and the memory array (slave).
// Strobes and address/data flow master->slave; read data and status flow back.
interface tag_mem_array_if;
  logic [2:0]  mem_sel;
  logic        PC_B;
  logic        WE;
  logic        SE;
  logic [5:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_read_out;
  logic        wr_done;
  logic        access_err;
  logic        busy;

  modport master (
    output mem_sel, PC_B, WE, SE, mem_address, mem_data_in,
    input  mem_read_out, wr_done, access_err, busy
  );

  modport slave (
    input  mem_sel, PC_B, WE, SE, mem_address, mem_data_in,
    output mem_read_out, wr_done, access_err, busy
  );
endinterface

// File: rtl/tag_mem_array.sv
// Three-bank (EPC, sensor-1, sensor-2) tag memory responder with protocol checking.
// Read data one edge after address in EVAL; writes commit the edge after WE falls; no backpressure.
module tag_mem_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  tag_mem_array_if.slave bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DEPTH_L = 7'(DEPTH);

  typedef enum logic [1:0] {
    PRECHARGE,
    EVAL,
    SENSE,
    WRITE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       bank_q;
  logic [1:0]       bank_nxt;
  logic             bank_vld;
  logic             bank_vld_nxt;
  logic [2:0]       sel_prev;
  logic [WIDTH-1:0] rd_reg;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] wr_latch;
  logic [5:0]       wr_addr;
  logic             we_q;
  logic             wr_done_q;
  logic             access_err_q;

  logic             err_nxt;
  logic             commit;
  logic             load_rd;
  logic             load_wr;
  logic             sel_onehot;
  logic [1:0]       sel_idx;
  logic             rd_addr_ok;
  logic             wr_addr_ok;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;

  logic [WIDTH-1:0] mem [0:2][0:DEPTH-1];

  always_comb begin
    sel_onehot = 1'b1;
    sel_idx    = 2'd0;
    case (bus.mem_sel)
      3'b001:  sel_idx = 2'd0;
      3'b010:  sel_idx = 2'd1;
      3'b100:  sel_idx = 2'd2;
      default: sel_onehot = 1'b0;
    endcase
  end

  assign rd_addr_ok = {1'b0, bus.mem_address} < DEPTH_L;
  assign wr_addr_ok = {1'b0, wr_addr} < DEPTH_L;
  assign rd_idx     = bus.mem_address[AW-1:0];
  assign wr_idx     = wr_addr[AW-1:0];

  // An invalid bank or out-of-range address reads as zero rather than array contents.
  assign rd_data = (bank_vld && rd_addr_ok) ? mem[bank_q][rd_idx] : '0;

  always_comb begin
    state_nxt    = state;
    bank_nxt     = bank_q;
    bank_vld_nxt = bank_vld;
    err_nxt      = 1'b0;
    commit       = 1'b0;
    load_rd      = 1'b0;
    load_wr      = 1'b0;

    if (state != PRECHARGE && bus.mem_sel != sel_prev)
      err_nxt = 1'b1;

    case (state)
      PRECHARGE: begin
        if (bus.WE || bus.SE)
          err_nxt = 1'b1;
        if (!bus.PC_B) begin
          state_nxt    = EVAL;
          bank_nxt     = sel_idx;
          bank_vld_nxt = sel_onehot;
          if (!sel_onehot)
            err_nxt = 1'b1;
        end
      end
      EVAL: begin
        load_rd = 1'b1;
        load_wr = bus.WE;
        if (bus.SE && bus.WE) begin
          err_nxt   = 1'b1;
          state_nxt = PRECHARGE;
        end else if (bus.SE) begin
          state_nxt = SENSE;
        end else if (bus.WE) begin
          state_nxt = WRITE;
        end else if (bus.PC_B) begin
          state_nxt = PRECHARGE;
        end
      end
      SENSE: begin
        load_rd = 1'b1;
        if (bus.SE && bus.WE) begin
          err_nxt   = 1'b1;
          state_nxt = PRECHARGE;
        end else if (bus.PC_B || !bus.SE) begin
          state_nxt = PRECHARGE;
        end
      end
      WRITE: begin
        load_wr = bus.WE;
        if (bus.SE && bus.WE) begin
          err_nxt   = 1'b1;
          state_nxt = PRECHARGE;
        end else if (we_q && !bus.WE) begin
          // Falling edge of WE: commit regardless of PC_B, drop if bank/address invalid.
          state_nxt = PRECHARGE;
          if (!wr_addr_ok)
            err_nxt = 1'b1;
          else if (bank_vld)
            commit = 1'b1;
        end
      end
      default: state_nxt = PRECHARGE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PRECHARGE;
      bank_q       <= 2'd0;
      bank_vld     <= 1'b0;
      sel_prev     <= 3'b000;
      rd_reg       <= '0;
      wr_latch     <= '0;
      wr_addr      <= 6'd0;
      we_q         <= 1'b0;
      wr_done_q    <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      bank_q       <= bank_nxt;
      bank_vld     <= bank_vld_nxt;
      sel_prev     <= bus.mem_sel;
      we_q         <= bus.WE;
      wr_done_q    <= commit;
      access_err_q <= err_nxt;
      if (load_rd)
        rd_reg <= rd_data;
      if (load_wr) begin
        wr_latch <= bus.mem_data_in;
        wr_addr  <= bus.mem_address;
      end
    end
  end

  // Array contents survive reset; a reset on the commit edge discards the write.
  always_ff @(posedge clk) begin
    if (commit && !reset)
      mem[bank_q][wr_idx] <= wr_latch;
  end

  assign bus.mem_read_out = bus.SE ? rd_reg : '0;
  assign bus.wr_done      = wr_done_q;
  assign bus.access_err   = access_err_q;
  assign bus.busy         = (state != PRECHARGE);

endmodule

// File: tb/tb_tag_mem_array.sv
// Directed bench for tag_mem_array: DEPTH=64 and DEPTH=32 instances driven in lockstep.
module tb_tag_mem_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel;
  logic        pcb;
  logic        we;
  logic        se;
  logic [5:0]  addr;
  logic [15:0] din;

  int total = 0;
  int bad   = 0;

  int n_done64 = 0;
  int n_err64  = 0;
  int n_done32 = 0;
  int n_err32  = 0;
  int b_done64, b_err64, b_done32, b_err32;

  logic        pulse;
  logic [15:0] q64;
  logic [15:0] q32;

  tag_mem_array_if b64 ();
  tag_mem_array_if b32 ();

  assign b64.mem_sel     = sel;
  assign b64.PC_B        = pcb;
  assign b64.WE          = we;
  assign b64.SE          = se;
  assign b64.mem_address = addr;
  assign b64.mem_data_in = din;
  assign b32.mem_sel     = sel;
  assign b32.PC_B        = pcb;
  assign b32.WE          = we;
  assign b32.SE          = se;
  assign b32.mem_address = addr;
  assign b32.mem_data_in = din;

  tag_mem_array #(.DEPTH(64), .WIDTH(16)) dut64 (.clk(clk), .reset(reset), .bus(b64));
  tag_mem_array #(.DEPTH(32), .WIDTH(16)) dut32 (.clk(clk), .reset(reset), .bus(b32));

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (b64.wr_done === 1'b1)    n_done64 <= n_done64 + 1;
    if (b64.access_err === 1'b1) n_err64  <= n_err64 + 1;
    if (b32.wr_done === 1'b1)    n_done32 <= n_done32 + 1;
    if (b32.access_err === 1'b1) n_err32  <= n_err32 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_done64 = n_done64;
    b_err64  = n_err64;
    b_done32 = n_done32;
    b_err32  = n_err32;
  endtask

  // WE high for three cycles, data one cycle behind WE; pulse = wr_done after the commit edge.
  task automatic do_write(input logic [2:0] s, input logic [5:0] a, input logic [15:0] d,
                          output logic p);
    step(); sel = s; pcb = 1'b0;
    step(); addr = a;
    step(); we = 1'b1;
    step(); din = d;
    step();
    step(); we = 1'b0; pcb = 1'b1;
    step(); p = b64.wr_done;
    step();
  endtask

  // s_mid is applied to mem_sel together with SE to exercise a mid-access select change.
  task automatic do_read(input logic [2:0] s, input logic [5:0] a, input logic [2:0] s_mid,
                         output logic [15:0] r64, output logic [15:0] r32);
    step(); sel = s; pcb = 1'b0;
    step(); addr = a;
    step(); se = 1'b1; sel = s_mid;
    step(); r64 = b64.mem_read_out; r32 = b32.mem_read_out;
    se = 1'b0; pcb = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; sel = 3'b000; pcb = 1'b1; we = 1'b0; se = 1'b0; addr = 6'd0; din = 16'h0000;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_read_out", b64.mem_read_out, 16'h0000);
    check("rst_wr_done", b64.wr_done, 1'b0);
    check("rst_access_err", b64.access_err, 1'b0);
    check("rst_busy", b64.busy, 1'b0);

    // SE while precharged: output shows the cleared rd_reg, strobe flagged and ignored.
    se = 1'b1;
    #1;
    check("pre_se_read_out", b64.mem_read_out, 16'h0000);
    step();
    check("pre_se_err", b64.access_err, 1'b1);
    check("pre_se_busy", b64.busy, 1'b0);
    se = 1'b0;
    step();

    snap();
    do_write(3'b001, 6'd2, 16'hA5C3, pulse);
    check("wr1_done_timing", pulse, 1'b1);
    check("wr1_done_count", n_done64 - b_done64, 1);
    check("wr1_err_count", n_err64 - b_err64, 0);
    do_read(3'b001, 6'd2, 3'b001, q64, q32);
    check("rd1_epc2", q64, 16'hA5C3);

    do_write(3'b001, 6'd0, 16'h0E0E, pulse);
    do_write(3'b010, 6'd0, 16'h1111, pulse);
    do_write(3'b100, 6'd0, 16'h2222, pulse);
    do_read(3'b010, 6'd0, 3'b010, q64, q32);
    check("iso_s1", q64, 16'h1111);
    do_read(3'b100, 6'd0, 3'b100, q64, q32);
    check("iso_s2", q64, 16'h2222);
    do_read(3'b001, 6'd0, 3'b001, q64, q32);
    check("iso_epc", q64, 16'h0E0E);

    snap();
    do_read(3'b010, 6'd0, 3'b100, q64, q32);
    check("selchg_data", q64, 16'h1111);
    check("selchg_err", n_err64 - b_err64, 1);
    sel = 3'b001;

    // SE and WE together at addr 5 must not overwrite the stored value.
    do_write(3'b001, 6'd5, 16'h5555, pulse);
    snap();
    step(); sel = 3'b001; pcb = 1'b0;
    step(); addr = 6'd5; din = 16'hDEAD;
    step(); we = 1'b1; se = 1'b1;
    step();
    check("sewe_err_pulse", b64.access_err, 1'b1);
    we = 1'b0; se = 1'b0; pcb = 1'b1;
    step();
    check("sewe_no_done", n_done64 - b_done64, 0);
    check("sewe_err_count", n_err64 - b_err64, 1);
    do_read(3'b001, 6'd5, 3'b001, q64, q32);
    check("sewe_old_value", q64, 16'h5555);

    snap();
    do_read(3'b011, 6'd2, 3'b011, q64, q32);
    check("badsel_read_zero", q64, 16'h0000);
    check("badsel_rd_err", n_err64 - b_err64, 1);
    snap();
    do_write(3'b011, 6'd2, 16'hBEEF, pulse);
    check("badsel_wr_no_done", n_done64 - b_done64, 0);
    check("badsel_wr_err", n_err64 - b_err64, 1);
    do_read(3'b001, 6'd2, 3'b001, q64, q32);
    check("badsel_epc2_kept", q64, 16'hA5C3);

    // Reset mid-write discards the pending 16'hFFFF.
    do_write(3'b001, 6'd7, 16'h7777, pulse);
    snap();
    step(); sel = 3'b001; pcb = 1'b0;
    step(); addr = 6'd7;
    step(); we = 1'b1;
    step(); din = 16'hFFFF;
    step(); reset = 1'b1;
    step(); reset = 1'b0; we = 1'b0; pcb = 1'b1;
    check("rstwr_busy", b64.busy, 1'b0);
    step();
    step();
    check("rstwr_no_done", n_done64 - b_done64, 0);
    do_read(3'b001, 6'd7, 3'b001, q64, q32);
    check("rstwr_addr7_kept", q64, 16'h7777);

    // Address 40 is valid for DEPTH=64 but out of range for DEPTH=32.
    snap();
    do_write(3'b001, 6'd40, 16'h00FF, pulse);
    check("d64_a40_done", n_done64 - b_done64, 1);
    check("d64_a40_err", n_err64 - b_err64, 0);
    check("d32_a40_done", n_done32 - b_done32, 0);
    check("d32_a40_err", n_err32 - b_err32, 1);
    do_read(3'b001, 6'd40, 3'b001, q64, q32);
    check("d64_a40_read", q64, 16'h00FF);
    check("d32_a40_read", q32, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
